// File: rtl/cut_position_pkg.sv
// Shared state encoding, default line geometry and width helper for the cut-position scaler.
package cut_position_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_ADD  = 3'd3,
        ST_DONE = 3'd4
    } cut_pos_state_e;

    localparam int CUT_POS_DEFAULT_OFFSET = 16;
    localparam int CUT_POS_DEFAULT_SPAN   = 1400;

    function automatic int cut_pos_dw(input int raw_w, input int pos_w);
        return raw_w + pos_w;
    endfunction

endpackage

// File: rtl/cut_position_divider.sv
// Iterative restoring divider by the constant 2^DIVISOR_W - 1, one quotient bit per cycle, MSB first.
module cut_position_divider #(
    parameter int DIVIDEND_W = 19,
    parameter int DIVISOR_W  = 8,
    parameter int QUOT_W     = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [DIVIDEND_W-1:0] dividend_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [QUOT_W-1:0]     quotient_o
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);
    localparam logic [DIVISOR_W:0] DIVISOR = {1'b0, {DIVISOR_W{1'b1}}};

    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic [QUOT_W-1:0]     quot_q, quot_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic [DIVISOR_W:0]    trial;
    logic                  fits;

    // Only the low QUOT_W quotient bits are kept; the caller guarantees the rest are zero.
    always_comb begin
        dvd_d  = dvd_q;
        rem_d  = rem_q;
        quot_d = quot_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        trial  = {rem_q, dvd_q[DIVIDEND_W-1]};
        fits   = (trial >= DIVISOR);
        if (start_i) begin
            dvd_d  = dividend_i;
            rem_d  = '0;
            quot_d = '0;
            cnt_d  = CNT_W'(DIVIDEND_W);
            busy_d = 1'b1;
        end else if (busy_q) begin
            dvd_d  = dvd_q << 1;
            rem_d  = fits ? DIVISOR_W'(trial - DIVISOR) : trial[DIVISOR_W-1:0];
            quot_d = {quot_q[QUOT_W-2:0], fits};
            cnt_d  = cnt_q - CNT_W'(1);
            busy_d = (cnt_q != CNT_W'(1));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dvd_q  <= '0;
            rem_q  <= '0;
            quot_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            dvd_q  <= dvd_d;
            rem_q  <= rem_d;
            quot_q <= quot_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = busy_q && (cnt_q == CNT_W'(1));
    assign quotient_o = quot_q;

endmodule

// File: rtl/cut_position_scaler.sv
// Scales a raw key-stream value into an aligned cut position inside [offset, offset+span].
// Optional saturation on position overflow: define CUT_POS_SATURATE_EN.
//
// state   | meaning
// IDLE    | ready, latch raw/offset/span on in_valid
// MUL     | form raw*span, start divider
// DIV     | divider shifting out quotient bits
// ADD     | align quotient, add offset, register result
// DONE    | result held until out_ready
module cut_position_scaler
    import cut_position_pkg::*;
#(
    parameter int RAW_W      = 8,
    parameter int POS_W      = 11,
    parameter int ALIGN_LOG2 = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RAW_W-1:0] raw_cut_position,
    input  logic [POS_W-1:0] cfg_offset,
    input  logic [POS_W-1:0] cfg_span,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [POS_W-1:0] cut_position,
    output logic             overflow
);

    localparam int DW = cut_pos_dw(RAW_W, POS_W);
    localparam logic [POS_W-1:0] ALIGN_MASK = ~POS_W'((1 << ALIGN_LOG2) - 1);

    cut_pos_state_e   state_q;
    logic [RAW_W-1:0] raw_q;
    logic [POS_W-1:0] offset_q;
    logic [POS_W-1:0] span_q;
    logic             out_valid_q;
    logic [POS_W-1:0] cut_q;
    logic             ovf_q;

    logic [DW-1:0]    product;
    logic             div_start;
    logic             div_busy;
    logic             div_done;
    logic [POS_W-1:0] quotient;
    logic [POS_W-1:0] aligned;
    logic [POS_W-1:0] result;
    logic             result_ovf;

    assign product   = DW'(raw_q) * DW'(span_q);
    assign div_start = (state_q == ST_MUL);
    assign aligned   = quotient & ALIGN_MASK;

`ifdef CUT_POS_SATURATE_EN
    localparam logic [POS_W-1:0] SAT_VAL = {POS_W{1'b1}} & ALIGN_MASK;
    logic [POS_W:0] sum;
    assign sum        = {1'b0, offset_q} + {1'b0, aligned};
    assign result_ovf = sum[POS_W];
    assign result     = sum[POS_W] ? SAT_VAL : sum[POS_W-1:0];
`else
    assign result     = offset_q + aligned;
    assign result_ovf = 1'b0;
`endif

    cut_position_divider #(
        .DIVIDEND_W (DW),
        .DIVISOR_W  (RAW_W),
        .QUOT_W     (POS_W)
    ) u_divider (
        .clk        (clk),
        .reset      (reset),
        .start_i    (div_start),
        .dividend_i (product),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (quotient)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            raw_q       <= '0;
            offset_q    <= '0;
            span_q      <= '0;
            out_valid_q <= 1'b0;
            cut_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        raw_q    <= raw_cut_position;
                        offset_q <= cfg_offset;
                        span_q   <= cfg_span;
                        state_q  <= ST_MUL;
                    end
                end
                ST_MUL:  state_q <= ST_DIV;
                ST_DIV: begin
                    if (div_busy && div_done) state_q <= ST_ADD;
                end
                ST_ADD: begin
                    cut_q       <= result;
                    ovf_q       <= result_ovf;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready     = (state_q == ST_IDLE) && !reset;
    assign out_valid    = out_valid_q;
    assign cut_position = cut_q;
    assign overflow     = ovf_q;

endmodule
